// File: rtl/sram_arbiter.sv
// Arbitrates one SRAM-handshake memory port between instruction fetch and data access.
// One outstanding transaction at a time; results come back as registered one-cycle pulses.
module sram_arbiter #(
  parameter int unsigned DATA_PRIO_MAX = 4,
  parameter int unsigned TIMEOUT_CYC   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stallreq_inst,
  output logic        stallreq_data,
  output logic        bus_err
);

  localparam int unsigned PrioW = $clog2(DATA_PRIO_MAX + 1);
  localparam logic [PrioW-1:0] PrioMax = PrioW'(DATA_PRIO_MAX);
  localparam logic [7:0] ToMax  = 8'(TIMEOUT_CYC);
  localparam logic [7:0] ToLast = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StIAddr, StIData, StDAddr, StDData} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       wen_q, wen_d;
  logic             cancel_q, cancel_d;
  logic [PrioW-1:0] prio_cnt_q, prio_cnt_d;
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic             inst_ok_q, inst_ok_d, data_ok_q, data_ok_d;
  logic [31:0]      inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
  logic             bus_err_q, bus_err_d;
  logic             inst_eff, data_eff, grant_inst, grant_data;

  // A side is masked during its own ok cycle; a flush also hides a new fetch.
  assign inst_eff   = inst_req & ~inst_ok_q & ~flush;
  assign data_eff   = data_req & ~data_ok_q;
  assign grant_data = (state_q == StIdle) & data_eff & (~inst_eff | (prio_cnt_q < PrioMax));
  assign grant_inst = (state_q == StIdle) & inst_eff & ~grant_data;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    cancel_d     = cancel_q;
    prio_cnt_d   = prio_cnt_q;
    to_cnt_d     = to_cnt_q;
    inst_ok_d    = 1'b0;
    data_ok_d    = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    bus_err_d    = bus_err_q;

    unique case (state_q)
      StIdle: begin
        cancel_d = 1'b0;
        if (grant_data) begin
          addr_d  = data_addr;
          wen_d   = data_wen;
          wdata_d = data_wdata;
          state_d = StDAddr;
        end else if (grant_inst) begin
          addr_d  = inst_addr;
          wen_d   = 4'h0;
          wdata_d = 32'h0;
          state_d = StIAddr;
        end
      end
      StIAddr: begin
        // An accepted address must still be drained, so a concurrent flush only cancels.
        if (bus_addr_ok) begin
          state_d  = StIData;
          cancel_d = flush;
          to_cnt_d = 8'h0;
        end else if (flush) begin
          state_d = StIdle;
        end
      end
      StDAddr: begin
        if (bus_addr_ok) begin
          state_d  = StDData;
          to_cnt_d = 8'h0;
        end
      end
      StIData: begin
        if (bus_data_ok) begin
          state_d  = StIdle;
          cancel_d = 1'b0;
          if (!(cancel_q || flush)) begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = bus_rdata;
          end
        end else begin
          cancel_d = cancel_q | flush;
        end
      end
      StDData: begin
        if (bus_data_ok) begin
          state_d      = StIdle;
          data_ok_d    = 1'b1;
          data_rdata_d = bus_rdata;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StIData || state_q == StDData) && !bus_data_ok) begin
      if (to_cnt_q != ToMax) to_cnt_d = to_cnt_q + 8'h1;
      if (to_cnt_q == ToLast) bus_err_d = 1'b1;
    end

    if (grant_data && inst_req) begin
      if (prio_cnt_q < PrioMax) prio_cnt_d = prio_cnt_q + 1'b1;
    end else if (grant_inst || !inst_req) begin
      prio_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      addr_q       <= 32'h0;
      wen_q        <= 4'h0;
      wdata_q      <= 32'h0;
      cancel_q     <= 1'b0;
      prio_cnt_q   <= '0;
      to_cnt_q     <= 8'h0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      cancel_q     <= cancel_d;
      prio_cnt_q   <= prio_cnt_d;
      to_cnt_q     <= to_cnt_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Bus payload is zeroed outside the address phase.
  assign bus_req       = (state_q == StIAddr) || (state_q == StDAddr);
  assign bus_addr      = bus_req ? addr_q : 32'h0;
  assign bus_wdata     = bus_req ? wdata_q : 32'h0;
  assign bus_wstrb     = bus_req ? wen_q : 4'h0;
  assign bus_wr        = bus_req & (|wen_q);
  assign inst_ok       = inst_ok_q;
  assign data_ok       = data_ok_q;
  assign inst_rdata    = inst_rdata_q;
  assign data_rdata    = data_rdata_q;
  assign bus_err       = bus_err_q;
  assign stallreq_inst = inst_req & ~inst_ok_q;
  assign stallreq_data = data_req & ~data_ok_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int PRIO_MAX = 4;
  localparam int TIMEOUT  = 255;
  localparam logic [31:0] IA = 32'hBFC0_0000;
  localparam logic [31:0] DA = 32'h8000_1000;

  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic        inst_req = 1'b0, data_req = 1'b0, bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0, bus_rdata = '0;
  logic [3:0]  data_wen = '0;
  logic        inst_ok, data_ok, bus_req, bus_wr, stallreq_inst, stallreq_data, bus_err;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.DATA_PRIO_MAX(PRIO_MAX), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ok(inst_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ok(data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stallreq_inst(stallreq_inst), .stallreq_data(stallreq_data),
    .bus_err(bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctrl_vec();
    return 32'({bus_req, bus_wr, bus_wstrb, inst_ok, data_ok, stallreq_inst, stallreq_data,
                bus_err});
  endfunction

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; data_wen = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  // Drive the memory side through one full handshake; returns in the ok cycle.
  task automatic serve(input logic [31:0] rd);
    bus_addr_ok = 1'b1; tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = rd; tick();
    bus_data_ok = 1'b0;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!bus_req && n < 20) begin tick(); n++; end
    checks++;
    if (!bus_req) begin
      failures++;
      $display("FAIL %s grant_timeout bus_req=0 required=1", name);
    end
  endtask

  typedef struct {
    logic ireq, dreq, fl, aok, dok;
    logic [31:0] rdata;
    logic e_breq, e_bwr;
    logic [31:0] e_baddr;
    logic e_iok, e_dok;
    logic [31:0] e_irdata;
  } vec_t;

  function automatic vec_t mk(input logic ir, dr, fl, ao, dk, input logic [31:0] rd,
                              input logic br, bw, input logic [31:0] ba,
                              input logic io, dko, input logic [31:0] ird);
    vec_t v;
    v.ireq = ir; v.dreq = dr; v.fl = fl; v.aok = ao; v.dok = dk; v.rdata = rd;
    v.e_breq = br; v.e_bwr = bw; v.e_baddr = ba; v.e_iok = io; v.e_dok = dko; v.e_irdata = ird;
    return v;
  endfunction

  // Transaction-level reference model state
  logic        m_valid, m_is_data, m_addr_done, m_cancel, m_err, m_iok, m_dok;
  int          m_waited, m_prio;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic [3:0]  m_wen;

  task automatic model_reset();
    m_valid = 0; m_is_data = 0; m_addr_done = 0; m_cancel = 0; m_err = 0;
    m_iok = 0; m_dok = 0; m_waited = 0; m_prio = 0;
    m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0; m_wen = 0;
  endtask

  task automatic model_step();
    logic n_iok = 0, n_dok = 0, gi = 0, gd = 0, ie, de;
    if (m_valid) begin
      if (!m_addr_done) begin
        if (bus_addr_ok) begin
          m_addr_done = 1; m_waited = 0; m_cancel = !m_is_data && flush;
        end else if (!m_is_data && flush) begin
          m_valid = 0;
        end
      end else begin
        if (!m_is_data && flush) m_cancel = 1;
        if (bus_data_ok) begin
          if (m_is_data) begin n_dok = 1; m_drdata = bus_rdata; end
          else if (!m_cancel) begin n_iok = 1; m_irdata = bus_rdata; end
          m_valid = 0; m_cancel = 0;
        end else begin
          m_waited++;
          if (m_waited >= TIMEOUT) m_err = 1;
        end
      end
    end else begin
      ie = inst_req && !m_iok && !flush;
      de = data_req && !m_dok;
      gd = de && (!ie || m_prio < PRIO_MAX);
      gi = ie && !gd;
      if (gd || gi) begin
        m_valid = 1; m_is_data = gd; m_addr_done = 0; m_cancel = 0;
        m_addr  = gd ? data_addr : inst_addr;
        m_wen   = gd ? data_wen : 4'h0;
        m_wdata = gd ? data_wdata : 32'h0;
      end
    end
    if (gd && inst_req) m_prio = (m_prio < PRIO_MAX) ? m_prio + 1 : PRIO_MAX;
    else if (gi || !inst_req) m_prio = 0;
    m_iok = n_iok; m_dok = n_dok;
  endtask

  vec_t vecs[27];
  logic [31:0] exp_addr;
  logic i_drop, d_drop, prev_flush, e_breq;

  initial begin
    vecs[0]  = mk(1,0,0,0,0,0,            0,0,0,  0,0,0);
    vecs[1]  = mk(1,0,0,1,0,0,            1,0,IA, 0,0,0);
    vecs[2]  = mk(1,0,0,0,1,32'h3C1A0001, 0,0,0,  0,0,0);
    vecs[3]  = mk(1,0,0,0,0,0,            0,0,0,  1,0,32'h3C1A0001);
    vecs[4]  = mk(0,0,0,0,0,0,            0,0,0,  0,0,32'h3C1A0001);
    vecs[5]  = mk(1,1,0,0,0,0,            0,0,0,  0,0,32'h3C1A0001);
    vecs[6]  = mk(1,1,0,1,0,0,            1,1,DA, 0,0,32'h3C1A0001);
    vecs[7]  = mk(1,1,0,0,1,0,            0,0,0,  0,0,32'h3C1A0001);
    vecs[8]  = mk(1,1,0,0,0,0,            0,0,0,  0,1,32'h3C1A0001);
    vecs[9]  = mk(1,0,0,1,0,0,            1,0,IA, 0,0,32'h3C1A0001);
    vecs[10] = mk(1,0,0,0,1,32'h11111111, 0,0,0,  0,0,32'h3C1A0001);
    vecs[11] = mk(1,0,0,0,0,0,            0,0,0,  1,0,32'h11111111);
    vecs[12] = mk(0,0,0,0,0,0,            0,0,0,  0,0,32'h11111111);
    vecs[13] = mk(1,0,0,0,0,0,            0,0,0,  0,0,32'h11111111);
    vecs[14] = mk(1,0,1,0,0,0,            1,0,IA, 0,0,32'h11111111);
    vecs[15] = mk(0,0,0,0,0,0,            0,0,0,  0,0,32'h11111111);
    vecs[16] = mk(1,0,0,0,0,0,            0,0,0,  0,0,32'h11111111);
    vecs[17] = mk(1,0,0,1,0,0,            1,0,IA, 0,0,32'h11111111);
    vecs[18] = mk(1,0,1,0,0,0,            0,0,0,  0,0,32'h11111111);
    vecs[19] = mk(0,0,0,0,0,0,            0,0,0,  0,0,32'h11111111);
    vecs[20] = mk(0,0,0,0,0,0,            0,0,0,  0,0,32'h11111111);
    vecs[21] = mk(0,0,0,0,1,32'hDEADBEEF, 0,0,0,  0,0,32'h11111111);
    vecs[22] = mk(0,0,0,0,0,0,            0,0,0,  0,0,32'h11111111);
    vecs[23] = mk(1,0,0,0,0,0,            0,0,0,  0,0,32'h11111111);
    vecs[24] = mk(1,0,1,1,0,0,            1,0,IA, 0,0,32'h11111111);
    vecs[25] = mk(0,0,0,0,1,32'hCAFEF00D, 0,0,0,  0,0,32'h11111111);
    vecs[26] = mk(0,0,0,0,0,0,            0,0,0,  0,0,32'h11111111);

    // Reset state
    #1;
    check("reset_ctrl", ctrl_vec(), 32'h0);
    check("reset_bus_addr", bus_addr, 32'h0);
    check("reset_inst_rdata", inst_rdata, 32'h0);
    check("reset_data_rdata", data_rdata, 32'h0);
    do_reset();

    // Directed vector table: basic fetch, arbitration, flush in both phases
    inst_addr = IA; data_addr = DA; data_wen = 4'hF; data_wdata = 32'h12345678;
    for (int i = 0; i < 27; i++) begin
      inst_req = vecs[i].ireq; data_req = vecs[i].dreq; flush = vecs[i].fl;
      bus_addr_ok = vecs[i].aok; bus_data_ok = vecs[i].dok; bus_rdata = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d_bus_req", i), 32'(bus_req), 32'(vecs[i].e_breq));
      check($sformatf("vec%0d_bus_wr", i), 32'(bus_wr), 32'(vecs[i].e_bwr));
      check($sformatf("vec%0d_bus_addr", i), bus_addr, vecs[i].e_baddr);
      check($sformatf("vec%0d_inst_ok", i), 32'(inst_ok), 32'(vecs[i].e_iok));
      check($sformatf("vec%0d_data_ok", i), 32'(data_ok), 32'(vecs[i].e_dok));
      check($sformatf("vec%0d_inst_rdata", i), inst_rdata, vecs[i].e_irdata);
      check($sformatf("vec%0d_stall_inst", i), 32'(stallreq_inst),
            32'(vecs[i].ireq & ~vecs[i].e_iok));
      check($sformatf("vec%0d_stall_data", i), 32'(stallreq_data),
            32'(vecs[i].dreq & ~vecs[i].e_dok));
      @(posedge clk); #1;
    end

    // Fairness: n data grants while inst_req pends (hidden by flush), then contend
    for (int n = 3; n <= 4; n++) begin
      do_reset();
      inst_req = 1; inst_addr = IA; flush = 1;
      data_wen = 4'h0; data_addr = DA;
      for (int k = 0; k < n; k++) begin
        data_req = 1; tick();
        wait_grant("fair_load");
        serve(32'h0);
        check("fair_data_ok", 32'(data_ok), 32'h1);
        tick(); data_req = 0; tick();
      end
      flush = 0; data_req = 1; tick();
      exp_addr = (n >= PRIO_MAX) ? IA : DA;
      check($sformatf("fair_n%0d_bus_req", n), 32'(bus_req), 32'h1);
      check($sformatf("fair_n%0d_winner", n), bus_addr, exp_addr);
      if (n >= PRIO_MAX) begin
        serve(32'h0BAD0001);
        check("fair_inst_ok", 32'(inst_ok), 32'h1);
        tick(); inst_req = 0;
        check("fair_data_resume", bus_addr, DA);
      end
    end

    // Timeout: withhold bus_data_ok in D_DATA
    do_reset();
    data_req = 1; data_wen = 4'h0; data_addr = DA; tick();
    check("to_bus_req", 32'(bus_req), 32'h1);
    bus_addr_ok = 1; tick(); bus_addr_ok = 0;
    repeat (TIMEOUT - 1) tick();
    check("to_err_before", 32'(bus_err), 32'h0);
    tick();
    check("to_err_set", 32'(bus_err), 32'h1);
    bus_data_ok = 1; bus_rdata = 32'hA5A5_5A5A; tick(); bus_data_ok = 0;
    check("to_data_ok", 32'(data_ok), 32'h1);
    check("to_data_rdata", data_rdata, 32'hA5A5_5A5A);
    tick(); data_req = 0; tick();
    check("to_err_sticky", 32'(bus_err), 32'h1);
    check("to_ok_done", 32'(data_ok), 32'h0);

    // Asynchronous reset in D_ADDR, then a fresh fetch
    do_reset();
    data_req = 1; data_wen = 4'hF; data_addr = DA; data_wdata = 32'h55AA55AA; tick();
    check("rst_mid_bus_req", 32'(bus_req), 32'h1);
    #2; rst = 0; data_req = 0; #1;
    check("rst_mid_ctrl", ctrl_vec(), 32'h0);
    check("rst_mid_addr", bus_addr, 32'h0);
    check("rst_mid_wdata", bus_wdata, 32'h0);
    tick(); rst = 1;
    inst_req = 1; inst_addr = 32'h1FC0_0010; tick();
    check("rst_fresh_addr", bus_addr, 32'h1FC0_0010);
    serve(32'h2409_0007);
    check("rst_fresh_ok", 32'(inst_ok), 32'h1);
    check("rst_fresh_rdata", inst_rdata, 32'h2409_0007);
    tick(); inst_req = 0; tick();

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    i_drop = 0; d_drop = 0; prev_flush = 0;
    for (int c = 0; c < 3000; c++) begin
      if (i_drop) begin inst_req = 0; i_drop = 0; end
      else if (!inst_req) begin
        if ($urandom_range(0, 3) == 0) begin inst_req = 1; inst_addr = $urandom; end
      end else if (prev_flush && $urandom_range(0, 1) == 0) inst_req = 0;
      if (inst_req && m_iok) i_drop = 1;
      if (d_drop) begin data_req = 0; d_drop = 0; end
      else if (!data_req && $urandom_range(0, 3) == 0) begin
        data_req = 1; data_addr = $urandom; data_wdata = $urandom;
        data_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
      if (data_req && m_dok) d_drop = 1;
      flush = ($urandom_range(0, 9) == 0);
      bus_addr_ok = 1'($urandom_range(0, 1));
      bus_data_ok = ($urandom_range(0, 2) == 0);
      bus_rdata = $urandom;
      #1;
      e_breq = m_valid && !m_addr_done;
      check("rnd_ctrl", ctrl_vec(),
            32'({e_breq, e_breq && (m_wen != 0), e_breq ? m_wen : 4'h0, m_iok, m_dok,
                 inst_req && !m_iok, data_req && !m_dok, m_err}));
      check("rnd_bus_addr", bus_addr, e_breq ? m_addr : 32'h0);
      check("rnd_bus_wdata", bus_wdata, e_breq ? m_wdata : 32'h0);
      check("rnd_inst_rdata", inst_rdata, m_irdata);
      check("rnd_data_rdata", data_rdata, m_drdata);
      model_step();
      prev_flush = flush;
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
